rf_multiport_sb: RTL and testbench

- Parametrised successor to the single-cycle register file, for the pipelined core.
- Provides NUM_RD combinational read ports and two prioritised synchronous write ports: WB stage and late-load return.
- Write-first bypass inside the array path; a per-register busy scoreboard (set at issue, cleared at writeback) lets the hazard unit stall.
- Register 0 is hardwired to zero and is never busy.

---
 rtl/rf_multiport_sb_pkg.sv | 9 +
 rtl/rf_multiport_sb_read_port.sv | 53 +++++
 rtl/rf_multiport_sb.sv | 106 ++++++++++
 tb/tb_rf_multiport_sb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rf_multiport_sb_pkg.sv
// Shared constants for the multi-port register file with busy scoreboard.
package rf_multiport_sb_pkg;

  localparam int unsigned REG_ZERO     = 0;
  localparam bit          WR_PRI_PORT1 = 1'b1;
  localparam int unsigned NUM_RD_MIN   = 1;
  localparam int unsigned NUM_RD_MAX   = 4;

endpackage

// File: rtl/rf_multiport_sb_read_port.sv
// One combinational read port: zero-register decode, write-first bypass and
// busy qualification against writes landing this cycle.
module rf_multiport_sb_read_port
  import rf_multiport_sb_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  rst_i,
  input  logic [REG_WIDTH-1:0]  r_reg_i,
  input  logic [WORD_WIDTH-1:0] arr_data_i,
  input  logic                  arr_busy_i,
  input  logic                  we0_i,
  input  logic [REG_WIDTH-1:0]  w_reg0_i,
  input  logic [WORD_WIDTH-1:0] w_data0_i,
  input  logic                  we1_i,
  input  logic [REG_WIDTH-1:0]  w_reg1_i,
  input  logic [WORD_WIDTH-1:0] w_data1_i,
  output logic [WORD_WIDTH-1:0] r_data_o,
  output logic                  r_busy_o
);

  localparam logic [REG_WIDTH-1:0] ZERO_ADDR = REG_WIDTH'(REG_ZERO);

  logic hit0_s;
  logic hit1_s;

  assign hit0_s = (BYPASS != 0) && we0_i && (w_reg0_i == r_reg_i);
  assign hit1_s = (BYPASS != 0) && we1_i && (w_reg1_i == r_reg_i);

  // A forwarded write means the producer completes now, so it is no longer busy.
  always_comb begin
    r_data_o = '0;
    r_busy_o = 1'b0;
    if (rst_i || (r_reg_i == ZERO_ADDR)) begin
      r_data_o = '0;
      r_busy_o = 1'b0;
    end else begin
      if (hit1_s && (WR_PRI_PORT1 || !hit0_s)) begin
        r_data_o = w_data1_i;
      end else if (hit0_s) begin
        r_data_o = w_data0_i;
      end else if (hit1_s) begin
        r_data_o = w_data1_i;
      end else begin
        r_data_o = arr_data_i;
      end
      r_busy_o = arr_busy_i && !(hit0_s || hit1_s);
    end
  end

endmodule

// File: rtl/rf_multiport_sb.sv
// Register file with NUM_RD combinational read ports, two prioritised write
// ports and a per-register busy scoreboard for the hazard unit.
module rf_multiport_sb
  import rf_multiport_sb_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_RD*REG_WIDTH-1:0]  R_REG,
  output logic [NUM_RD*WORD_WIDTH-1:0] R_DATA,
  output logic [NUM_RD-1:0]            R_BUSY,
  input  logic                         WE0,
  input  logic [REG_WIDTH-1:0]         W_REG0,
  input  logic [WORD_WIDTH-1:0]        W_DATA0,
  input  logic                         WE1,
  input  logic [REG_WIDTH-1:0]         W_REG1,
  input  logic [WORD_WIDTH-1:0]        W_DATA1,
  input  logic                         ISSUE_EN,
  input  logic [REG_WIDTH-1:0]         ISSUE_REG,
  output logic [2**REG_WIDTH-1:0]      BUSY_VEC
);

  localparam int DEPTH = 2**REG_WIDTH;
  localparam logic [REG_WIDTH-1:0] ZERO_ADDR = REG_WIDTH'(REG_ZERO);

  if ((NUM_RD < int'(NUM_RD_MIN)) || (NUM_RD > int'(NUM_RD_MAX))) begin : g_bad_num_rd
    $error("rf_multiport_sb: NUM_RD must be in 1..4");
  end

  logic [WORD_WIDTH-1:0] regs_q [DEPTH];
  logic [WORD_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic                  wr0_s;
  logic                  wr1_s;
  logic                  same_addr_s;

  assign wr0_s       = WE0 && (W_REG0 != ZERO_ADDR);
  assign wr1_s       = WE1 && (W_REG1 != ZERO_ADDR);
  assign same_addr_s = wr0_s && wr1_s && (W_REG0 == W_REG1);

  // Issue is applied after the clears: a new producer is younger than the one completing.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
      busy_d = '0;
    end else begin
      if (wr0_s && !(same_addr_s && WR_PRI_PORT1)) begin
        regs_d[W_REG0] = W_DATA0;
        busy_d[W_REG0] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
      if (wr1_s && !(same_addr_s && !WR_PRI_PORT1)) begin
        regs_d[W_REG1] = W_DATA1;
        busy_d[W_REG1] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
      if (ISSUE_EN && (ISSUE_REG != ZERO_ADDR)) begin
        busy_d[ISSUE_REG] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
  end

  assign BUSY_VEC = RST ? '0 : {busy_q[DEPTH-1:1], 1'b0};

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_multiport_sb_read_port #(
      .WORD_WIDTH(WORD_WIDTH),
      .REG_WIDTH (REG_WIDTH),
      .BYPASS    (BYPASS)
    ) u_rd (
      .rst_i     (RST),
      .r_reg_i   (R_REG[k*REG_WIDTH +: REG_WIDTH]),
      .arr_data_i(regs_q[R_REG[k*REG_WIDTH +: REG_WIDTH]]),
      .arr_busy_i(busy_q[R_REG[k*REG_WIDTH +: REG_WIDTH]]),
      .we0_i     (WE0),
      .w_reg0_i  (W_REG0),
      .w_data0_i (W_DATA0),
      .we1_i     (WE1),
      .w_reg1_i  (W_REG1),
      .w_data1_i (W_DATA1),
      .r_data_o  (R_DATA[k*WORD_WIDTH +: WORD_WIDTH]),
      .r_busy_o  (R_BUSY[k])
    );
  end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Randomised and directed bench for rf_multiport_sb, run with and without bypass
// side by side on shared stimulus against an array-based reference model.
module tb_rf_multiport_sb;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  R_REG = '0;
  logic        WE0 = 1'b0, WE1 = 1'b0, ISSUE_EN = 1'b0;
  logic [4:0]  W_REG0 = '0, W_REG1 = '0, ISSUE_REG = '0;
  logic [31:0] W_DATA0 = '0, W_DATA1 = '0;

  logic [63:0] rd_b, rd_n;
  logic [1:0]  busy_b, busy_n;
  logic [31:0] vec_b, vec_n;

  logic [31:0] mem [32];
  logic [31:0] bsy;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 CLK = ~CLK;

  rf_multiport_sb #(.WORD_WIDTH(32), .REG_WIDTH(5), .NUM_RD(2), .BYPASS(1)) u_byp (
    .CLK(CLK), .RST(RST), .R_REG(R_REG), .R_DATA(rd_b), .R_BUSY(busy_b),
    .WE0(WE0), .W_REG0(W_REG0), .W_DATA0(W_DATA0),
    .WE1(WE1), .W_REG1(W_REG1), .W_DATA1(W_DATA1),
    .ISSUE_EN(ISSUE_EN), .ISSUE_REG(ISSUE_REG), .BUSY_VEC(vec_b));

  rf_multiport_sb #(.WORD_WIDTH(32), .REG_WIDTH(5), .NUM_RD(2), .BYPASS(0)) u_nobyp (
    .CLK(CLK), .RST(RST), .R_REG(R_REG), .R_DATA(rd_n), .R_BUSY(busy_n),
    .WE0(WE0), .W_REG0(W_REG0), .W_DATA0(W_DATA0),
    .WE1(WE1), .W_REG1(W_REG1), .W_DATA1(W_DATA1),
    .ISSUE_EN(ISSUE_EN), .ISSUE_REG(ISSUE_REG), .BUSY_VEC(vec_n));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_data(input int k, input bit byp);
    logic [4:0] a;
    a = R_REG[k*5 +: 5];
    if (RST || a == 5'd0) return 32'd0;
    if (byp && WE1 && W_REG1 == a) return W_DATA1;
    if (byp && WE0 && W_REG0 == a) return W_DATA0;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input int k, input bit byp);
    logic [4:0] a;
    a = R_REG[k*5 +: 5];
    if (RST || a == 5'd0) return 1'b0;
    if (byp && ((WE1 && W_REG1 == a) || (WE0 && W_REG0 == a))) return 1'b0;
    return bsy[a];
  endfunction

  // Reference state: what the architectural registers and scoreboard hold after each edge.
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      bsy = 32'd0;
    end else begin
      if (WE0 && W_REG0 != 5'd0) begin mem[W_REG0] = W_DATA0; bsy[W_REG0] = 1'b0; end
      if (WE1 && W_REG1 != 5'd0) begin mem[W_REG1] = W_DATA1; bsy[W_REG1] = 1'b0; end
      if (ISSUE_EN && ISSUE_REG != 5'd0) bsy[ISSUE_REG] = 1'b1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      logic [31:0] ev;
      ev = RST ? 32'd0 : {bsy[31:1], 1'b0};
      for (int k = 0; k < 2; k++) begin
        check($sformatf("byp_rdata%0d", k), {32'd0, rd_b[k*32 +: 32]}, {32'd0, exp_data(k, 1'b1)});
        check($sformatf("nobyp_rdata%0d", k), {32'd0, rd_n[k*32 +: 32]}, {32'd0, exp_data(k, 1'b0)});
      end
      check("byp_rbusy", {62'd0, busy_b}, {62'd0, exp_busy(1, 1'b1), exp_busy(0, 1'b1)});
      check("nobyp_rbusy", {62'd0, busy_n}, {62'd0, exp_busy(1, 1'b0), exp_busy(0, 1'b0)});
      check("byp_busyvec", {32'd0, vec_b}, {32'd0, ev});
      check("nobyp_busyvec", {32'd0, vec_n}, {32'd0, ev});
    end
  end

  task automatic idle();
    WE0 = 1'b0; WE1 = 1'b0; ISSUE_EN = 1'b0; RST = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    R_REG = {a1, a0};
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    WE0 = 1'b1; W_REG0 = a; W_DATA0 = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    WE1 = 1'b1; W_REG1 = a; W_DATA1 = d;
  endtask

  task automatic iss(input logic [4:0] a);
    ISSUE_EN = 1'b1; ISSUE_REG = a;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    bsy = 32'd0;
    RST = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    idle();
    for (int r = 1; r < 32; r++) begin
      rd(r[4:0], r[4:0]);
      @(negedge CLK);
      check("reset_rd", {32'd0, rd_b[31:0]}, 64'd0);
      check("reset_vec", {32'd0, vec_b}, 64'd0);
      step();
    end

    wr0(5'd5, 32'h1234_5678); step(); idle();
    rd(5'd5, 5'd5); @(negedge CLK);
    check("r5_p0", {32'd0, rd_b[31:0]}, 64'h1234_5678);
    check("r5_p1", {32'd0, rd_n[63:32]}, 64'h1234_5678);
    wr0(5'd0, 32'hFFFF_FFFF); step(); idle();
    rd(5'd0, 5'd0); @(negedge CLK);
    check("r0_zero", {32'd0, rd_b[31:0]}, 64'd0);
    step();

    wr0(5'd7, 32'hA5A5_0001); rd(5'd7, 5'd5); @(negedge CLK);
    check("bypass_same_cycle", {32'd0, rd_b[31:0]}, 64'hA5A5_0001);
    check("nobypass_old", {32'd0, rd_n[31:0]}, 64'd0);
    step(); idle(); @(negedge CLK);
    check("nobypass_next", {32'd0, rd_n[31:0]}, 64'hA5A5_0001);
    step();

    wr0(5'd9, 32'h11); wr1(5'd9, 32'h22); step(); idle();
    rd(5'd9, 5'd9); @(negedge CLK);
    check("double_write", {32'd0, rd_b[31:0]}, 64'h22);
    step();

    iss(5'd3); step(); idle(); rd(5'd3, 5'd0); @(negedge CLK);
    check("issue_vec", {63'd0, vec_b[3]}, 64'd1);
    check("issue_rbusy", {63'd0, busy_b[0]}, 64'd1);
    step();
    wr1(5'd3, 32'h99); iss(5'd3); @(negedge CLK);
    check("wb_bypass_busy", {63'd0, busy_b[0]}, 64'd0);
    check("wb_nobypass_busy", {63'd0, busy_n[0]}, 64'd1);
    step(); idle(); @(negedge CLK);
    check("set_wins", {63'd0, vec_b[3]}, 64'd1);
    check("r3_data", {32'd0, rd_n[31:0]}, 64'h99);
    step();
    wr0(5'd3, 32'h5); step(); idle(); @(negedge CLK);
    check("busy_cleared", {63'd0, vec_b[3]}, 64'd0);
    step();

    wr0(5'd4, 32'h55); step(); idle();
    iss(5'd4); step(); idle();
    iss(5'd6); step(); idle();
    RST = 1'b1; wr0(5'd6, 32'h77); rd(5'd4, 5'd6); @(negedge CLK);
    check("rst_rdata", rd_b, 64'd0);
    check("rst_vec", {32'd0, vec_b}, 64'd0);
    step(); idle(); @(negedge CLK);
    check("post_rst_r6", {32'd0, rd_b[63:32]}, 64'd0);
    check("post_rst_vec", {32'd0, vec_n}, 64'd0);
    step();

    for (int c = 0; c < 1500; c++) begin
      RST      = ($urandom_range(0, 99) < 3);
      WE0      = $urandom_range(0, 1);
      WE1      = ($urandom_range(0, 2) == 0);
      ISSUE_EN = $urandom_range(0, 1);
      W_REG0   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      W_REG1   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ISSUE_REG = 5'($urandom_range(0, 7));
      W_DATA0  = $urandom;
      W_DATA1  = $urandom;
      R_REG    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step();
    end
    idle();
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
